// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             we_hi_i,
   input  logic             we_lo_i,
   input  logic [WIDTH-1:0] wd_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               bz_q, bz_d;
   // opa holds |A| for multiply, and the dividend/quotient shift register for divide
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   // product accumulator: upper half is the running sum, lower half shifts out B
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic               accept;
   logic               signed_op;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // operand conditioning and per-iteration arithmetic
   always_comb begin
      accept    = (state_q == S_IDLE) && start_i;
      signed_op = ~op_i[0];
      a_neg     = signed_op & a_i[WIDTH-1];
      b_neg     = signed_op & b_i[WIDTH-1];
      a_abs     = a_neg ? (-a_i) : a_i;
      b_abs     = b_neg ? (-b_i) : b_i;

      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);

      div_trial = {rem_q, opa_q[WIDTH-1]};
      div_ge    = div_trial >= {1'b0, opb_q};
      // only used when the trial fits, so the modular subtract is exact
      div_sub   = div_trial[WIDTH-1:0] - opb_q;

      prod_fix  = neg_res_q ? (-prod_q) : prod_q;
      quo_fix   = neg_res_q ? (-opa_q) : opa_q;
      rem_fix   = neg_rem_q ? (-rem_q) : rem_q;
   end

   // next-state logic: IDLE -> CALC (32 iterations) -> FIX -> IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CALC;
               cnt_d   = 5'd0;
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
         end
      endcase
   end

   // datapath next-state: capture, iterate, sign-fix and HI/LO writes
   always_comb begin
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      bz_d      = bz_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      prod_d    = prod_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // MTHI/MTLO land even when an operation is accepted on the same edge
            if (we_hi_i) begin
               hi_d = wd_i;
            end
            if (we_lo_i) begin
               lo_d = wd_i;
            end
            if (accept) begin
               is_div_d  = op_i[1];
               neg_res_d = signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               neg_rem_d = signed_op & a_i[WIDTH-1];
               bz_d      = op_i[1] && (b_i == '0);
               opa_d     = a_abs;
               opb_d     = b_abs;
               prod_d    = {{WIDTH{1'b0}}, b_abs};
               rem_d     = '0;
            end
         end
         S_CALC: begin
            if (is_div_q) begin
               rem_d = div_ge ? div_sub : div_trial[WIDTH-1:0];
               opa_d = {opa_q[WIDTH-2:0], div_ge};
            end else begin
               prod_d = {mul_sum, prod_q[WIDTH-1:1]};
            end
         end
         S_FIX: begin
            done_d = 1'b1;
            dbz_d  = is_div_q && bz_q;
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (!bz_q) begin
               // -2^31 / -1 falls out naturally: |q| = 0x8000_0000, no negation
               lo_d = quo_fix;
               hi_d = rem_fix;
            end
         end
         default: begin
         end
      endcase
   end

   // state register with synchronous active-high reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         bz_q      <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         prod_q    <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         bz_q      <= bz_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         prod_q    <= prod_d;
         rem_q     <= rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wd;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   int          vectors;
   int          miss;
   logic [31:0] model_hi;
   logic [31:0] model_lo;
   logic        model_dbz;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .op_i          (op),
      .a_i           (a),
      .b_i           (b),
      .we_hi_i       (we_hi),
      .we_lo_i       (we_lo),
      .wd_i          (wd),
      .busy_o        (busy),
      .done_o        (done),
      .div_by_zero_o (dbz),
      .hi_o          (hi),
      .lo_o          (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // architectural result of one operation on the current HI/LO model
   function automatic void model_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
      longint      sa, sb, p, q, r;
      logic [63:0] pu;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      model_dbz = 1'b0;
      case (o)
         2'b00: begin
            p = sa * sb;
            pu = p;
            model_hi = pu[63:32];
            model_lo = pu[31:0];
         end
         2'b01: begin
            pu = {32'd0, av} * {32'd0, bv};
            model_hi = pu[63:32];
            model_lo = pu[31:0];
         end
         2'b10: begin
            if (bv == 32'd0) begin
               model_dbz = 1'b1;
            end else begin
               q = sa / sb;
               r = sa % sb;
               pu = q;
               model_lo = pu[31:0];
               pu = r;
               model_hi = pu[31:0];
            end
         end
         default: begin
            if (bv == 32'd0) begin
               model_dbz = 1'b1;
            end else begin
               model_lo = av / bv;
               model_hi = av % bv;
            end
         end
      endcase
   endfunction

   // runs one operation from a negedge, optional same-cycle MT write and mid-op disturbance
   task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic wh, input logic wl, input logic [31:0] wv,
                        input bit disturb, input string name);
      int k;
      op = o; a = av; b = bv; start = 1'b1;
      we_hi = wh; we_lo = wl; wd = wv;
      if (wh) model_hi = wv;
      if (wl) model_lo = wv;
      model_op(o, av, bv);
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom; wd = $urandom;
      vectors++;
      if (busy !== 1'b1) begin
         miss++;
         $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
         if (disturb && k == 4) begin
            start = 1'b1; we_lo = 1'b1; wd = 32'hDEAD_BEEF; op = 2'b01; a = 32'd9; b = 32'd9;
         end else if (disturb && k == 5) begin
            start = 1'b0; we_lo = 1'b0;
         end
      end
      vectors++;
      if (k !== 33) begin
         miss++;
         $display("FAIL %s latency: got %0d want 33", name, k);
      end
      vectors++;
      if (hi !== model_hi) begin
         miss++;
         $display("FAIL %s hi: got %h want %h (op %b a %h b %h)", name, hi, model_hi, o, av, bv);
      end
      vectors++;
      if (lo !== model_lo) begin
         miss++;
         $display("FAIL %s lo: got %h want %h (op %b a %h b %h)", name, lo, model_lo, o, av, bv);
      end
      vectors++;
      if (dbz !== model_dbz) begin
         miss++;
         $display("FAIL %s div_by_zero: got %b want %b", name, dbz, model_dbz);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miss++;
         $display("FAIL %s busy_at_done: got %b want 0", name, busy);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || dbz !== 1'b0) begin
         miss++;
         $display("FAIL %s pulse_width: got done %b dbz %b want 0 0", name, done, dbz);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      we_hi = 1'b0; we_lo = 1'b0; wd = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         miss++;
         $display("FAIL reset_state: got busy %b done %b dbz %b hi %h lo %h want all 0",
                  busy, done, dbz, hi, lo);
      end
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
   endtask

   task automatic test_mult();
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, "multu_max");
      vectors++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         miss++;
         $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", hi, lo);
      end
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, "mult_neg1");
      vectors++;
      if (hi !== 32'd0 || lo !== 32'd1) begin
         miss++;
         $display("FAIL mult_neg1_const: got %h_%h want 00000000_00000001", hi, lo);
      end
   endtask

   task automatic test_div();
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0, "div_neg7");
      vectors++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         miss++;
         $display("FAIL div_neg7_const: got hi %h lo %h want ffffffff fffffffd", hi, lo);
      end
      do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, '0, 1'b0, "divu_100_7");
      vectors++;
      if (lo !== 32'd14 || hi !== 32'd2) begin
         miss++;
         $display("FAIL divu_100_7_const: got hi %h lo %h want 2 14", hi, lo);
      end
   endtask

   task automatic test_div_by_zero();
      we_hi = 1'b1; wd = 32'h1234;
      @(negedge clk);
      we_hi = 1'b0; we_lo = 1'b1; wd = 32'h5678;
      @(negedge clk);
      we_lo = 1'b0;
      model_hi = 32'h1234;
      model_lo = 32'h5678;
      vectors++;
      if (hi !== 32'h1234 || lo !== 32'h5678) begin
         miss++;
         $display("FAIL mthi_mtlo: got hi %h lo %h want 1234 5678", hi, lo);
      end
      do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b0, "div_by_zero");
      vectors++;
      if (hi !== 32'h1234 || lo !== 32'h5678) begin
         miss++;
         $display("FAIL div_by_zero_hold: got hi %h lo %h want 1234 5678", hi, lo);
      end
   endtask

   task automatic test_overflow_busy();
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b1, "div_overflow");
      vectors++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
         miss++;
         $display("FAIL div_overflow_const: got hi %h lo %h want 0 80000000", hi, lo);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      op = 2'b00; a = $urandom; b = $urandom | 32'h1; start = 1'b1;
      we_hi = 1'b1; we_lo = 1'b1; wd = 32'hA5A5_0001;
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
         miss++;
         $display("FAIL reset_abort_state: got busy %b done %b hi %h lo %h want 0 0 0 0",
                  busy, done, hi, lo);
      end
      reset = 1'b0;
      model_hi = '0;
      model_lo = '0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miss++;
         $display("FAIL reset_abort_no_done: got %0d done pulses want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
      @(negedge clk);
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (k !== 33 || lo !== 32'd12 || hi !== 32'd0) begin
         miss++;
         $display("FAIL b2b_first: got latency %0d hi %h lo %h want 33 0 c", k, hi, lo);
      end
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miss++;
         $display("FAIL b2b_restart: got busy %b done %b want 1 0", busy, done);
      end
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (k !== 33 || lo !== 32'd12 || hi !== 32'd0) begin
         miss++;
         $display("FAIL b2b_second: got latency %0d hi %h lo %h want 33 0 c", k, hi, lo);
      end
      @(negedge clk);
      model_hi = 32'd0;
      model_lo = 32'd12;
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] av, bv;
      logic        wh, wl;
      for (int i = 0; i < 60; i++) begin
         o  = 2'($urandom_range(0, 3));
         av = $urandom;
         bv = $urandom;
         case ($urandom_range(0, 7))
            0: bv = 32'd0;
            1: bv = 32'hFFFF_FFFF;
            2: bv = $urandom_range(1, 15);
            3: av = 32'h8000_0000;
            default: ;
         endcase
         wh = ($urandom_range(0, 3) == 0);
         wl = ($urandom_range(0, 3) == 0);
         do_op(o, av, bv, wh, wl, $urandom, 1'b0, "random");
      end
   endtask

   initial begin
      vectors = 0;
      miss = 0;
      model_dbz = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_div_by_zero();
      test_overflow_busy();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit that sits directly downstream of the register file in the datapath. It consumes the two read operands (RD1 → `a`, RD2 → `b`) for MULT/MULTU/DIV/DIVU. Results go into internal HI/LO registers, which the writeback path reads for MFHI/MFLO. A start/busy/done handshake lets control stall the pipeline while an operation is in progress.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported; the counter is sized for 32 iterations.
- `clk` input 1: clock; all state updates on posedge (the register file writes on negedge).
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: request an operation; sampled on a posedge only while the unit is not busy.
- `op` input 2: operation select. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- `a` input 32: operand A / dividend (from RD1).
- `b` input 32: operand B / divisor (from RD2).
- `we_hi` input 1: MTHI write enable.
- `we_lo` input 1: MTLO write enable.
- `wd` input 32: MTHI/MTLO write data.
- `busy` output 1: an operation is in progress; the hazard unit stalls on it.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `div_by_zero` output 1: valid with `done`; the completed DIV/DIVU had `b == 0`.
- `hi` output 32: HI register. Product upper word, or remainder.
- `lo` output 32: LO register. Product lower word, or quotient.

## Operation
- FSM states:
  - IDLE: `busy` = 0.
  - CALC: 32 iterations, 5-bit counter 0..31.
  - FIX: sign correction and HI/LO write.
  - FIX always returns to IDLE.
- Transitions:
  - IDLE → CALC on `start`.
  - CALC → FIX when counter = 31.
  - FIX → IDLE unconditionally.
- Operand capture on the accepting edge:
  - Signed ops store |a| and |b|, plus `neg_res = a[31]^b[31]` and `neg_rem = a[31]`.
  - Unsigned ops store the operands as-is, with both flags cleared.
- Multiply: radix-2 shift-add on a 64-bit accumulator, one bit of B per CALC cycle, LSB first.
- Divide: restoring, one quotient bit per CALC cycle, MSB first; the 33-bit partial remainder is compared against the divisor.
- FIX:
  - Multiply: negate the 64-bit product if `neg_res`.
  - Divide: negate the quotient if `neg_res`; negate the remainder if `neg_rem`.
  - This gives quotient truncation toward zero, with the remainder sign following the dividend.
- Overflow, −2^31 / −1: LO = 0x8000_0000, HI = 0; `div_by_zero` = 0.
- Divide by zero (`b == 0` on DIV/DIVU):
  - Latency is unchanged.
  - HI/LO are left unmodified.
  - `div_by_zero` = 1 in the `done` cycle.
- `start` while busy is ignored; it is not queued.
- `op`, `a` and `b` are don't-care after the accepting edge.
- MTHI/MTLO:
  - In IDLE, `we_hi`/`we_lo` write `wd` into HI/LO at the posedge; both may be written in the same cycle.
  - While busy, the writes are ignored.
  - If `start` and `we_*` occur in the same IDLE cycle, both are taken: the write lands now and the result overwrites it at FIX.
- Reset values: `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, state = IDLE, counter = 0.
- Reset mid-operation aborts at that edge: all outputs go to their reset values and no `done` is issued.

## Timing
- `start` is accepted at posedge N, when state = IDLE.
- `busy` = 1 from after edge N until edge N+33.
- CALC iterations run at edges N+1 … N+32.
- FIX executes at edge N+33, where HI/LO are written.
- From N+33 to N+34: `done` = 1, `busy` = 0, and the result is visible.
- Total latency: 33 cycles from the accepting edge to HI/LO valid, for every op, including divide by zero.
- Back-to-back operation:
  - A new `start` is accepted at edge N+34, i.e. in the cycle `done` is high.
  - That edge also deasserts `done` and reasserts `busy`.
- `done` and `div_by_zero` are single-cycle pulses; `div_by_zero` is 0 whenever `done` is 0.
- `hi`/`lo` change only at FIX, at an accepted MTHI/MTLO edge, or at reset.

## Test plan
- Multiply, both signednesses:
  - MULTU a = 0xFFFF_FFFF, b = 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001, `done` at N+33.
  - MULT on the same operands → HI = 0, LO = 1.
- DIV a = −7 (0xFFFF_FFF9), b = 2 → LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
- DIVU a = 100, b = 7 → LO = 14, HI = 2.
- Divide-by-zero path:
  - MTHI 0x1234, MTLO 0x5678, then DIV a = 5, b = 0.
  - After 33 cycles: `done` = 1, `div_by_zero` = 1, HI = 0x1234, LO = 0x5678.
- Overflow and busy protection:
  - DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
  - During that operation, pulse `start` and `we_lo` at N+5: both are ignored, and the result and latency are unchanged.
- Reset and back-to-back:
  - Assert `reset` at N+10 of a MULT → at the next edge `busy` = 0, HI = LO = 0, and no `done` pulse ever occurs.
  - Then issue MULTU 3 × 4 with `start` held high in the `done` cycle: the second operation starts at N+34, and LO = 12 after each.
